// File: rtl/pll_lock_seq_pkg.sv
// Shared types and helpers for the PLL lock / system reset sequencer.
package pll_lock_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } seq_state_e;

  localparam int LOCK_TIMEOUT_DEFAULT = 65536;

  // One shared timer covers the PLL reset pulse, the stable window and the lock timeout,
  // so it is sized for the longest of the three.
  function automatic int timer_width(input int timeout_cycles, input int rst_cycles,
                                     input int stable_cycles);
    int longest;
    longest = timeout_cycles;
    if (rst_cycles > longest) longest = rst_cycles;
    if (stable_cycles > longest) longest = stable_cycles;
    return (longest > 2) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module bit_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Pulses the PLL reset, waits for a stable lock, then releases the system reset.
// Optional saturating lock-loss counter: define PLL_LOCK_SEQ_LOSS_CNT_EN.
module pll_lock_reset_seq
  import pll_lock_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_DEFAULT,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             clear_fail,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             lock_fail,
  output logic [2:0]       seq_state,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int TW = timer_width(LOCK_TIMEOUT_CYCLES, PLL_RST_CYCLES, LOCK_STABLE_CYCLES);
  localparam int RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TW-1:0] RST_LAST     = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);

  seq_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          locked_s;
  logic          pll_rst_q, sys_rst_q, lock_fail_q;

  bit_sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PLL_RST;
      timer_q     <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      lock_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      pll_rst_q   <= (state_d == PLL_RST) || (state_d == FAIL);
      // Low only while staying in RUN: released one edge after entry, re-asserted on the
      // same edge that leaves RUN.
      sys_rst_q   <= !((state_q == RUN) && (state_d == RUN));
      lock_fail_q <= (state_d == FAIL);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    unique case (state_q)
      PLL_RST: begin
        if (timer_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_LOCK: begin
        // Lock is tested first so a lock arriving on the timeout cycle is not charged.
        if (locked_s) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          timer_d = '0;
          retry_d = retry_q + RW'(1);
          state_d = (retry_q == RETRY_LAST) ? FAIL : PLL_RST;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = RUN;
          timer_d = '0;
          retry_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RUN: begin
        retry_d = '0;
        timer_d = '0;
        if (!locked_s) state_d = PLL_RST;
      end
      FAIL: begin
        timer_d = '0;
        if (clear_fail) begin
          state_d = PLL_RST;
          retry_d = '0;
        end
      end
      default: begin
        state_d = PLL_RST;
        timer_d = '0;
        retry_d = '0;
      end
    endcase
  end

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  logic             loss_evt;
  logic [CNT_W-1:0] loss_cnt_q;

  assign loss_evt = (state_q == RUN) && !locked_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else if (loss_evt && (loss_cnt_q != {CNT_W{1'b1}})) begin
      loss_cnt_q <= loss_cnt_q + CNT_W'(1);
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = '0;
`endif

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign lock_fail = lock_fail_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq: per-cycle comparison against a phase/dwell model
// plus hand-computed latencies and counts.
module tb_pll_lock_reset_seq;

  localparam int P_RST    = 4;
  localparam int P_STABLE = 8;
  localparam int P_TO     = 32;
  localparam int P_MAXR   = 2;
  localparam int P_CNTW   = 8;
  localparam int CNT_MAX  = (1 << P_CNTW) - 1;

  localparam int PH_PLL_RST = 0;
  localparam int PH_WAIT    = 1;
  localparam int PH_STABLE  = 2;
  localparam int PH_RUN     = 3;
  localparam int PH_FAIL    = 4;

  // ---------------- clock / reset ----------------
  logic clk        = 1'b0;
  logic rst        = 1'b1;
  logic pll_locked = 1'b0;
  logic clear_fail = 1'b0;

  logic              pll_rst;
  logic              sys_rst;
  logic              lock_fail;
  logic [2:0]        seq_state;
  logic [P_CNTW-1:0] lock_loss_cnt;

  always #5 clk = ~clk;

  pll_lock_reset_seq #(
    .PLL_RST_CYCLES      (P_RST),
    .LOCK_STABLE_CYCLES  (P_STABLE),
    .LOCK_TIMEOUT_CYCLES (P_TO),
    .MAX_RETRIES         (P_MAXR),
    .CNT_W               (P_CNTW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .clear_fail    (clear_fail),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .lock_fail     (lock_fail),
    .seq_state     (seq_state),
    .lock_loss_cnt (lock_loss_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [P_CNTW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the phase and how long it has lasted; the lock level it acts on is the
  // pll_locked value seen two edges earlier.
  int m_phase  = PH_PLL_RST;
  int m_dwell  = 0;
  int m_tries  = 0;
  int m_losses = 0;
  bit m_sys    = 1'b1;
  bit m_seen   = 1'b0;
  bit m_ls     = 1'b0;
  int m_prev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  = PH_PLL_RST;
      m_dwell  = 0;
      m_tries  = 0;
      m_losses = 0;
      m_sys    = 1'b1;
      m_seen   = 1'b0;
      m_ls     = 1'b0;
    end else begin
      m_prev = m_phase;
      case (m_phase)
        PH_PLL_RST: begin
          m_dwell++;
          if (m_dwell == P_RST) begin
            m_phase = PH_WAIT;
            m_dwell = 0;
          end
        end
        PH_WAIT: begin
          if (m_ls) begin
            m_phase = PH_STABLE;
            m_dwell = 0;
          end else begin
            m_dwell++;
            if (m_dwell == P_TO) begin
              m_tries++;
              m_dwell = 0;
              m_phase = (m_tries >= P_MAXR) ? PH_FAIL : PH_PLL_RST;
            end
          end
        end
        PH_STABLE: begin
          if (!m_ls) begin
            m_phase = PH_WAIT;
            m_dwell = 0;
          end else begin
            m_dwell++;
            if (m_dwell == P_STABLE) begin
              m_phase = PH_RUN;
              m_dwell = 0;
              m_tries = 0;
            end
          end
        end
        PH_RUN: begin
          if (!m_ls) begin
            m_phase = PH_PLL_RST;
            m_dwell = 0;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
            if (m_losses < CNT_MAX) m_losses++;
`endif
          end
        end
        default: begin
          if (clear_fail) begin
            m_phase = PH_PLL_RST;
            m_dwell = 0;
            m_tries = 0;
          end
        end
      endcase
      m_sys  = !((m_prev == PH_RUN) && (m_phase == PH_RUN));
      m_ls   = m_seen;
      m_seen = pll_locked;
    end
  end

  always @(negedge clk) begin
    check("cyc_pll_rst",   32'(pll_rst),       32'((m_phase == PH_PLL_RST) || (m_phase == PH_FAIL)));
    check("cyc_sys_rst",   32'(sys_rst),       32'(m_sys));
    check("cyc_lock_fail", 32'(lock_fail),     32'(m_phase == PH_FAIL));
    check("cyc_seq_state", 32'(seq_state),     32'(m_phase));
    check("cyc_loss_cnt",  32'(lock_loss_cnt), 32'(m_losses));
  end

  // ---------------- driver tasks ----------------
  task automatic wait_sys(input logic level, input int budget, output int n);
    n = 0;
    while (sys_rst !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output int n);
    n = 0;
    while (seq_state !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pll_rst_width(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_clear_fail();
    clear_fail = 1'b1;
    @(negedge clk);
    clear_fail = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_pll_rst",   32'(pll_rst),       1);
    check("reset_sys_rst",   32'(sys_rst),       1);
    check("reset_lock_fail", 32'(lock_fail),     0);
    check("reset_state",     32'(seq_state),     PH_PLL_RST);
    check("reset_loss_cnt",  32'(lock_loss_cnt), 0);

    // 1: first lock; release latency = sync 2 + detect 1 + stable 8 + register 1
    rst = 1'b0;
    pll_rst_width(n);
    check("t1_pll_rst_width", n, 4);
    repeat (10) @(negedge clk);
    check("t1_still_waiting", 32'(seq_state), PH_WAIT);
    pll_locked = 1'b1;
    wait_sys(1'b0, 200, n);
    check("t1_release_latency", n, 12);

    // clear_fail outside FAIL must be ignored
    pulse_clear_fail();
    check("t1_clear_ignored", 32'(seq_state), PH_RUN);

    // 3: lock loss in RUN
    pll_locked = 1'b0;
    wait_sys(1'b1, 50, n);
    check("t3_sys_rst_latency", n, 3);
    pll_rst_width(n);
    check("t3_pll_rst_width", n, 4);
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    exp_q.push_back(P_CNTW'(1));
`else
    exp_q.push_back(P_CNTW'(0));
`endif
    check("t3_loss_cnt", 32'(lock_loss_cnt), 32'(exp_q.pop_front()));

    // 2: one-cycle glitch after 5 cycles in STABLE
    pll_locked = 1'b1;
    wait_state(3'(PH_STABLE), 50, n);
    check("t2_to_stable", n, 3);
    repeat (3) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    repeat (2) @(negedge clk);
    check("t2_back_to_wait", 32'(seq_state), PH_WAIT);
    wait_sys(1'b0, 200, n);
    check("t2_relock_latency", n, 10);

    // 5: 300 further losses saturate the counter
    for (int i = 0; i < 300; i++) begin
      wait_sys(1'b0, 100, n);
      if (n >= 100) check("t5_run_budget", n, 0);
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      wait_sys(1'b1, 10, n);
      if (n >= 10) check("t5_loss_budget", n, 0);
    end
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    exp_q.push_back(P_CNTW'(CNT_MAX));
`else
    exp_q.push_back(P_CNTW'(0));
`endif
    check("t5_loss_cnt_sat", 32'(lock_loss_cnt), 32'(exp_q.pop_front()));

    // 6: asynchronous reset while in STABLE
    wait_state(3'(PH_STABLE), 100, n);
    check("t6_reach_stable", 32'(seq_state), PH_STABLE);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6_pll_rst",   32'(pll_rst),   1);
    check("t6_sys_rst",   32'(sys_rst),   1);
    check("t6_lock_fail", 32'(lock_fail), 0);
    check("t6_state",     32'(seq_state), PH_PLL_RST);
    exp_q.push_back(P_CNTW'(0));
    check("t6_loss_cnt",  32'(lock_loss_cnt), 32'(exp_q.pop_front()));
    @(negedge clk);
    pll_locked = 1'b0;
    rst = 1'b0;

    // 4: no lock -> (4 + 32) x 2 cycles to FAIL
    n = 0;
    while (lock_fail !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t4_cycles_to_fail", n, 72);
    check("t4_fail_pll_rst", 32'(pll_rst), 1);
    check("t4_fail_state", 32'(seq_state), PH_FAIL);
    repeat (5) @(negedge clk);
    check("t4_fail_holds", 32'(lock_fail), 1);
    pulse_clear_fail();
    check("t4_clear_state", 32'(seq_state), PH_PLL_RST);
    check("t4_clear_lock_fail", 32'(lock_fail), 0);
    check("t4_clear_pll_rst", 32'(pll_rst), 1);

    // lock reaching locked_s on the last timeout cycle wins over the retry
    pll_rst_width(n);
    check("t4_restart_pll_rst_width", n, 4);
    repeat (29) @(negedge clk);
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_lock_beats_timeout", 32'(seq_state), PH_STABLE);
    wait_sys(1'b0, 50, n);
    check("t4_final_release", n, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
